// File: rtl/dm_cache_pkg.sv
// Shared defaults and address field extraction for the direct-mapped tag model.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package dm_cache_pkg;

    localparam int DEF_ADDR_W   = 32;
    localparam int DEF_OFFSET_W = 4;
    localparam int DEF_INDEX_W  = 6;
    localparam int DEF_CNT_W    = 32;
    localparam int DEF_TAG_W    = DEF_ADDR_W - DEF_OFFSET_W - DEF_INDEX_W;

    // Extraction works on a widened address so one function serves any build width.
    localparam int MAX_ADDR_W = 64;

    // Line index: the bits directly above the block offset.
    function automatic logic [MAX_ADDR_W-1:0] get_index(
        input logic [MAX_ADDR_W-1:0] addr,
        input int                    offset_w,
        input int                    index_w
    );
        logic [MAX_ADDR_W-1:0] mask;
        mask = (MAX_ADDR_W'(1) << index_w) - MAX_ADDR_W'(1);
        return (addr >> offset_w) & mask;
    endfunction

    // Tag: every bit above offset and index; caller slices to its tag width.
    function automatic logic [MAX_ADDR_W-1:0] get_tag(
        input logic [MAX_ADDR_W-1:0] addr,
        input int                    offset_w,
        input int                    index_w
    );
        return addr >> (offset_w + index_w);
    endfunction

endpackage

// File: rtl/dm_cache_tag_array.sv
// Valid/tag storage: combinational read port, synchronous write port, sync valid clear.
// Latency: read is combinational; a write is visible to reads right after its edge.
// Backpressure: none; one read and at most one write every cycle.
module dm_cache_tag_array #(
    parameter int INDEX_W = 6,
    parameter int TAG_W   = 22
) (
    input  logic               clk,
    input  logic               clr_n,
    input  logic [INDEX_W-1:0] rd_index,
    output logic               rd_valid,
    output logic [TAG_W-1:0]   rd_tag,
    input  logic               we,
    input  logic [INDEX_W-1:0] wr_index,
    input  logic [TAG_W-1:0]   wr_tag
);

    localparam int DEPTH = 1 << INDEX_W;

    logic [DEPTH-1:0] valid;
    logic [TAG_W-1:0] tags [DEPTH];

    // Valid bits: cleared wholesale by reset, set one entry at a time on allocation.
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            valid <= '0;
        end else if (we) begin
            valid[wr_index] <= 1'b1;
        end
    end

    // Tag contents carry no reset; the valid bit decides whether they mean anything.
    always_ff @(posedge clk) begin
        if (we) begin
            tags[wr_index] <= wr_tag;
        end
    end

    assign rd_valid = valid[rd_index];
    assign rd_tag   = tags[rd_index];

endmodule

// File: rtl/dm_cache.sv
// Direct-mapped cache tag model counting hits and misses of an address trace.
// Latency: 1 cycle from sampled address to updated counters.
// Backpressure: none; one lookup is consumed on every non-reset edge.
module dm_cache
    import dm_cache_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int OFFSET_W = DEF_OFFSET_W,
    parameter int INDEX_W  = DEF_INDEX_W,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] address,
    output logic [CNT_W-1:0]  hitCount,
    output logic [CNT_W-1:0]  missCount
);

    localparam int TAG_W = ADDR_W - OFFSET_W - INDEX_W;

    logic [MAX_ADDR_W-1:0] addr_ext;
    logic [MAX_ADDR_W-1:0] index_full;
    logic [MAX_ADDR_W-1:0] tag_full;
    logic [INDEX_W-1:0]    index;
    logic [TAG_W-1:0]      tag;
    logic                  entry_valid;
    logic [TAG_W-1:0]      entry_tag;
    logic                  hit;
    logic                  alloc;
    logic                  unused_bits;

    assign addr_ext   = MAX_ADDR_W'(address);
    assign index_full = get_index(addr_ext, OFFSET_W, INDEX_W);
    assign tag_full   = get_tag(addr_ext, OFFSET_W, INDEX_W);
    assign index      = index_full[INDEX_W-1:0];
    assign tag        = tag_full[TAG_W-1:0];

    // Upper bits of the widened fields are always zero; collected here to keep lint quiet.
    assign unused_bits = ^{index_full[MAX_ADDR_W-1:INDEX_W], tag_full[MAX_ADDR_W-1:TAG_W]};

    dm_cache_tag_array #(
        .INDEX_W (INDEX_W),
        .TAG_W   (TAG_W)
    ) u_tag_array (
        .clk      (clk),
        .clr_n    (rst_n),
        .rd_index (index),
        .rd_valid (entry_valid),
        .rd_tag   (entry_tag),
        .we       (alloc),
        .wr_index (index),
        .wr_tag   (tag)
    );

    assign hit   = entry_valid && (entry_tag == tag);
    // A miss replaces whatever the indexed line held; nothing is written during reset.
    assign alloc = rst_n && !hit;

    // Statistics: exactly one of the two counters advances per non-reset edge, wrapping freely.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hitCount  <= '0;
            missCount <= '0;
        end else if (hit) begin
            hitCount  <= hitCount + CNT_W'(1);
        end else begin
            missCount <= missCount + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_dm_cache.sv
module tb_dm_cache;

    logic        clk;
    logic        rst_n;
    logic [31:0] address;
    logic [31:0] hitCount;
    logic [31:0] missCount;

    // Narrow-counter build for the wrap scenario
    logic        rst_w;
    logic [31:0] addr_w;
    logic [3:0]  hit_w;
    logic [3:0]  miss_w;

    int n_checks;
    int n_fail;

    // Reference model: 64 lines of {valid, tag}, plain arithmetic on the address
    bit          m_valid [64];
    int unsigned m_tag   [64];
    int unsigned exp_hit;
    int unsigned exp_miss;

    dm_cache dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .address   (address),
        .hitCount  (hitCount),
        .missCount (missCount)
    );

    dm_cache #(.CNT_W(4)) dut_w (
        .clk       (clk),
        .rst_n     (rst_w),
        .address   (addr_w),
        .hitCount  (hit_w),
        .missCount (miss_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void model_reset();
        for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
        exp_hit  = 0;
        exp_miss = 0;
    endfunction

    function automatic void model_access(input logic [31:0] a);
        int unsigned idx;
        int unsigned tg;
        idx = (a / 16) % 64;
        tg  = a / 1024;
        if (m_valid[idx] && m_tag[idx] == tg) begin
            exp_hit = exp_hit + 1;
        end else begin
            exp_miss     = exp_miss + 1;
            m_valid[idx] = 1'b1;
            m_tag[idx]   = tg;
        end
    endfunction

    task automatic check_counts(input string name);
        n_checks++;
        if (hitCount !== exp_hit) begin
            n_fail++;
            $display("FAIL %s hitCount got=%0d exp=%0d", name, hitCount, exp_hit);
        end
        n_checks++;
        if (missCount !== exp_miss) begin
            n_fail++;
            $display("FAIL %s missCount got=%0d exp=%0d", name, missCount, exp_miss);
        end
    endtask

    task automatic do_access(input logic [31:0] a, input string name);
        rst_n   = 1'b1;
        address = a;
        @(posedge clk);
        #1;
        model_access(a);
        check_counts(name);
    endtask

    task automatic do_reset(input int edges, input string name);
        rst_n = 1'b0;
        repeat (edges) @(posedge clk);
        #1;
        model_reset();
        check_counts(name);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        address = 32'd858;
        do_reset(3, "reset");
        n_checks++;
        if (hitCount !== 32'd0 || missCount !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_zero hit=%0d miss=%0d exp=0/0", hitCount, missCount);
        end
    endtask

    task automatic test_basic();
        do_access(32'd858,  "basic_858_a");
        do_access(32'd858,  "basic_858_b");
        do_access(32'd2233, "basic_2233_a");
        do_access(32'd2233, "basic_2233_b");
        do_access(32'd858,  "basic_858_c");
        n_checks++;
        if (hitCount !== 32'd3 || missCount !== 32'd2) begin
            n_fail++;
            $display("FAIL basic_final hit=%0d miss=%0d exp=3/2", hitCount, missCount);
        end
    endtask

    task automatic test_conflict();
        do_reset(1, "conflict_reset");
        do_access(32'd858,  "conflict_858");
        do_access(32'd1882, "conflict_1882");
        do_access(32'd858,  "conflict_858_again");
        n_checks++;
        if (hitCount !== 32'd0 || missCount !== 32'd3) begin
            n_fail++;
            $display("FAIL conflict_final hit=%0d miss=%0d exp=0/3", hitCount, missCount);
        end
    endtask

    task automatic test_mid_reset();
        do_reset(1, "mid_reset");
        do_access(32'd858, "mid_reset_first");
        n_checks++;
        if (hitCount !== 32'd0 || missCount !== 32'd1) begin
            n_fail++;
            $display("FAIL mid_reset_after hit=%0d miss=%0d exp=0/1", hitCount, missCount);
        end
    endtask

    task automatic test_offset();
        do_reset(1, "offset_reset");
        do_access(32'd848, "offset_848");
        do_access(32'd863, "offset_863");
        n_checks++;
        if (hitCount !== 32'd1 || missCount !== 32'd1) begin
            n_fail++;
            $display("FAIL offset_final hit=%0d miss=%0d exp=1/1", hitCount, missCount);
        end
    endtask

    task automatic test_random();
        logic [31:0] a;
        int unsigned idx;
        int unsigned tg;
        int unsigned off;
        do_reset(1, "random_reset");
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 59) == 0) begin
                do_reset(1, "random_midreset");
            end else if ($urandom_range(0, 9) == 0) begin
                a = $urandom();
                do_access(a, "random_wide");
            end else begin
                idx = $urandom_range(0, 7);
                tg  = $urandom_range(0, 3);
                off = $urandom_range(0, 15);
                a   = tg * 1024 + idx * 16 + off;
                do_access(a, "random_pool");
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a;
        for (int n = 0; n < 20; n++) begin
            a = $urandom();
            do_access(a, "b2b_first");
            do_access(a ^ 32'h0000_000F, "b2b_second");
        end
    endtask

    task automatic test_wrap();
        rst_w  = 1'b0;
        addr_w = 32'h40;
        @(posedge clk);
        #1;
        rst_w = 1'b1;
        // one miss then fifteen hits brings the 4-bit hit counter to all-ones
        repeat (16) @(posedge clk);
        #1;
        n_checks++;
        if (hit_w !== 4'hF || miss_w !== 4'd1) begin
            n_fail++;
            $display("FAIL wrap_pre hit=%0d miss=%0d exp=15/1", hit_w, miss_w);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (hit_w !== 4'h0) begin
            n_fail++;
            $display("FAIL wrap_hit got=%0d exp=0", hit_w);
        end
        n_checks++;
        if (miss_w !== 4'd1) begin
            n_fail++;
            $display("FAIL wrap_miss got=%0d exp=1", miss_w);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        address  = 32'd0;
        rst_w    = 1'b0;
        addr_w   = 32'd0;
        model_reset();

        test_reset();
        test_basic();
        test_conflict();
        test_mid_reset();
        test_offset();
        test_random();
        test_back_to_back();
        test_wrap();

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
